// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter_pkg : shared encodings and bus widths for the memory-port arbiter
// Rev 1.0
// ============================================================================
package mem_port_arbiter_pkg;

    localparam int DEF_WORD_SIZE  = 16;
    localparam int DEF_FETCH_SIZE = 64;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_DONE   = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter_rr_arbiter2 : two-requester round-robin grant (I vs D), combinational
// Rev 1.0
// ============================================================================
module mem_port_arbiter_rr_arbiter2
    import mem_port_arbiter_pkg::*;
(
    input  logic   ireq_i,
    input  logic   dreq_i,
    input  owner_e last_i,
    output logic   valid_o,
    output owner_e owner_o
);

    always_comb begin
        valid_o = ireq_i | dreq_i;
        owner_o = OWN_I;
        if (ireq_i && dreq_i) begin
            // On contention the side that did not go last wins.
            owner_o = (last_i == OWN_I) ? OWN_D : OWN_I;
        end else if (dreq_i) begin
            owner_o = OWN_D;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter : shares one fixed-latency memory port between I and D cache paths
// Rev 1.0
// ============================================================================
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int WORD_SIZE  = DEF_WORD_SIZE,
    parameter int FETCH_SIZE = DEF_FETCH_SIZE,
    parameter int LATENCY    = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_req,
    input  logic [WORD_SIZE-1:0]  i_addr,
    output logic [FETCH_SIZE-1:0] i_rdata,
    output logic                  i_done,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [WORD_SIZE-1:0]  d_addr,
    input  logic [FETCH_SIZE-1:0] d_wdata,
    output logic [FETCH_SIZE-1:0] d_rdata,
    output logic                  d_done,
    output logic                  m_readM,
    output logic                  m_writeM,
    output logic [WORD_SIZE-1:0]  m_address,
    inout  wire  [FETCH_SIZE-1:0] m_data,
    output logic                  busy
);

    localparam int               CNT_W    = $clog2(LATENCY) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

    arb_state_e            state_q;
    owner_e                owner_q;
    owner_e                last_q;
    owner_e                gnt_owner_d;
    logic                  gnt_valid_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [WORD_SIZE-1:0]  addr_q;
    logic [FETCH_SIZE-1:0] wdata_q;
    logic [FETCH_SIZE-1:0] i_rdata_q;
    logic [FETCH_SIZE-1:0] d_rdata_q;
    logic                  readM_q;
    logic                  writeM_q;
    logic                  i_done_q;
    logic                  d_done_q;

    mem_port_arbiter_rr_arbiter2 u_rr (
        .ireq_i  (i_req),
        .dreq_i  (d_req),
        .last_i  (last_q),
        .valid_o (gnt_valid_d),
        .owner_o (gnt_owner_d)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ARB_IDLE;
            owner_q   <= OWN_I;
            last_q    <= OWN_I;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            readM_q   <= 1'b0;
            writeM_q  <= 1'b0;
            i_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
        end else begin
            i_done_q <= 1'b0;
            d_done_q <= 1'b0;
            case (state_q)
                ARB_IDLE: begin
                    cnt_q <= '0;
                    if (gnt_valid_d) begin
                        owner_q  <= gnt_owner_d;
                        addr_q   <= (gnt_owner_d == OWN_D) ? d_addr : i_addr;
                        wdata_q  <= d_wdata;
                        readM_q  <= !((gnt_owner_d == OWN_D) && d_we);
                        writeM_q <= (gnt_owner_d == OWN_D) && d_we;
                        state_q  <= ARB_ACCESS;
                    end
                end
                ARB_ACCESS: begin
                    last_q <= owner_q;
                    if (cnt_q == CNT_LAST) begin
                        cnt_q    <= '0;
                        readM_q  <= 1'b0;
                        writeM_q <= 1'b0;
                        // Strobe registers are still valid here, so writeM_q gives the type.
                        if (!writeM_q) begin
                            if (owner_q == OWN_I) i_rdata_q <= m_data;
                            else                  d_rdata_q <= m_data;
                        end
                        i_done_q <= (owner_q == OWN_I);
                        d_done_q <= (owner_q == OWN_D);
                        state_q  <= ARB_DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ARB_DONE: state_q <= ARB_IDLE;
                default:  state_q <= ARB_IDLE;
            endcase
        end
    end

    assign m_readM   = readM_q;
    assign m_writeM  = writeM_q;
    assign m_address = addr_q & ~WORD_SIZE'(3);
    assign m_data    = writeM_q ? wdata_q : {FETCH_SIZE{1'bz}};
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign i_done    = i_done_q;
    assign d_done    = d_done_q;
    assign busy      = (state_q != ARB_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_port_arbiter : randomized + directed bench with a transaction-timeline reference model
// Rev 1.0
// ============================================================================
module tb_mem_port_arbiter;

    localparam int L = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        i_req, d_req, d_we;
    logic [15:0] i_addr, d_addr;
    logic [63:0] d_wdata;
    logic [63:0] i_rdata, d_rdata;
    logic        i_done, d_done, m_readM, m_writeM, busy;
    logic [15:0] m_address;
    wire  [63:0] m_data;

    function automatic logic [63:0] init_line(input logic [7:0] idx);
        if (idx == 8'd9) return 64'h0123_4567_89AB_CDEF;
        return {idx, 8'h5A, idx ^ 8'h3C, 8'hE1, ~idx, 8'h96, idx + 8'd7, 8'h0F};
    endfunction

    // Memory device: answers reads combinationally, absorbs writes at the clock edge.
    logic [63:0] dev_mem [256];
    bit          dev_wr  [256];
    wire  [63:0] w_mem_drive = dev_wr[m_address[9:2]] ? dev_mem[m_address[9:2]]
                                                      : init_line(m_address[9:2]);
    assign m_data = m_writeM ? 64'bz : w_mem_drive;
    always @(posedge clk) begin
        if (m_writeM) begin
            dev_mem[m_address[9:2]] <= m_data;
            dev_wr[m_address[9:2]]  <= 1'b1;
        end
    end

    mem_port_arbiter #(.LATENCY(L)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done),
        .m_readM(m_readM), .m_writeM(m_writeM), .m_address(m_address),
        .m_data(m_data), .busy(busy)
    );

    // Latency-sweep instances, I-side reads only.
    logic        s_ireq;
    logic [15:0] s_iaddr;
    logic [63:0] s1_irdata, s1_drdata, s7_irdata, s7_drdata;
    logic        s1_idone, s1_ddone, s1_rd, s1_wr, s1_busy;
    logic        s7_idone, s7_ddone, s7_rd, s7_wr, s7_busy;
    logic [15:0] s1_maddr, s7_maddr;
    wire  [63:0] s1_mdata, s7_mdata;
    assign s1_mdata = s1_wr ? 64'bz : (init_line(s1_maddr[9:2]) ^ 64'h1111);
    assign s7_mdata = s7_wr ? 64'bz : (init_line(s7_maddr[9:2]) ^ 64'h7777);

    mem_port_arbiter #(.LATENCY(1)) s1 (
        .clk(clk), .reset_n(reset_n),
        .i_req(s_ireq), .i_addr(s_iaddr), .i_rdata(s1_irdata), .i_done(s1_idone),
        .d_req(1'b0), .d_we(1'b0), .d_addr(16'h0), .d_wdata(64'h0),
        .d_rdata(s1_drdata), .d_done(s1_ddone),
        .m_readM(s1_rd), .m_writeM(s1_wr), .m_address(s1_maddr),
        .m_data(s1_mdata), .busy(s1_busy)
    );

    mem_port_arbiter #(.LATENCY(7)) s7 (
        .clk(clk), .reset_n(reset_n),
        .i_req(s_ireq), .i_addr(s_iaddr), .i_rdata(s7_irdata), .i_done(s7_idone),
        .d_req(1'b0), .d_we(1'b0), .d_addr(16'h0), .d_wdata(64'h0),
        .d_rdata(s7_drdata), .d_done(s7_ddone),
        .m_readM(s7_rd), .m_writeM(s7_wr), .m_address(s7_maddr),
        .m_data(s7_mdata), .busy(s7_busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model: one transaction at a time on a cycle timeline.
    // A grant in IDLE cycle g gives access cycles g+1..g+L, done in g+L+1, next IDLE g+L+2.
    logic [63:0] sh_mem [256];
    bit          sh_wr  [256];
    bit          cur_v, cur_d, cur_we, last_d;
    int          g, next_free;
    logic [15:0] cur_addr;
    logic [63:0] cur_wdata, cur_rdata, exp_irdata, exp_drdata;
    bit          hold_reqs, rand_mode;
    bit          done_log[$];
    int          done_cyc[$];
    int          rd_cycles, wr_cycles;
    logic [63:0] obs_i_rdata;
    logic [15:0] obs_wr_addr;

    function automatic logic [63:0] model_mem(input logic [7:0] idx);
        return sh_wr[idx] ? sh_mem[idx] : init_line(idx);
    endfunction

    task automatic model_edge();
        bit pick_d;
        if (!reset_n) return;
        if (cyc >= next_free && (i_req || d_req)) begin
            pick_d    = (i_req && d_req) ? !last_d : d_req;
            cur_v     = 1'b1;
            g         = cyc;
            cur_d     = pick_d;
            last_d    = pick_d;
            cur_we    = pick_d && d_we;
            cur_addr  = (pick_d ? d_addr : i_addr) & 16'hFFFC;
            cur_wdata = d_wdata;
            if (cur_we) begin
                sh_mem[cur_addr[9:2]] = cur_wdata;
                sh_wr[cur_addr[9:2]]  = 1'b1;
            end else begin
                cur_rdata = model_mem(cur_addr[9:2]);
            end
            next_free = cyc + L + 2;
        end
    endtask

    task automatic check_cycle();
        bit in_acc, in_done;
        in_acc  = cur_v && (cyc > g) && (cyc <= g + L);
        in_done = cur_v && (cyc == g + L + 1);
        chk("m_readM",  m_readM,  in_acc && !cur_we);
        chk("m_writeM", m_writeM, in_acc && cur_we);
        chk("busy",     busy,     in_acc || in_done);
        chk("i_done",   i_done,   in_done && !cur_d);
        chk("d_done",   d_done,   in_done && cur_d);
        chk("strobe_excl", m_readM & m_writeM, 0);
        chk("done_excl",   i_done & d_done, 0);
        if (!m_writeM) chk("bus_release", m_data, w_mem_drive);
        if (m_readM) rd_cycles++;
        if (m_writeM) begin
            wr_cycles++;
            obs_wr_addr = m_address;
        end
        if (in_acc) chk("m_address", m_address, cur_addr);
        if (in_acc && cur_we) chk("m_data_write", m_data, cur_wdata);
        if (in_done) begin
            if (!cur_we) begin
                if (cur_d) exp_drdata = cur_rdata;
                else       exp_irdata = cur_rdata;
            end
            if (cur_d) chk("d_rdata", d_rdata, exp_drdata);
            else begin
                chk("i_rdata", i_rdata, exp_irdata);
                obs_i_rdata = i_rdata;
            end
            done_log.push_back(cur_d);
            done_cyc.push_back(cyc);
            cur_v = 1'b0;
        end
    endtask

    task automatic rand_drive();
        if (!i_req && $urandom_range(0, 2) == 0) begin
            i_req  = 1'b1;
            i_addr = 16'($urandom_range(0, 255)) | (16'($urandom_range(0, 1)) << 12);
        end
        if (!d_req && $urandom_range(0, 2) == 0) begin
            d_req   = 1'b1;
            d_we    = 1'($urandom_range(0, 1));
            d_addr  = 16'($urandom_range(0, 255)) | (16'($urandom_range(0, 1)) << 13);
            d_wdata = {$urandom, $urandom};
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        check_cycle();
        if (i_done && !hold_reqs) i_req = 1'b0;
        if (d_done && !hold_reqs) d_req = 1'b0;
        if (rand_mode) rand_drive();
    endtask

    task automatic do_reset();
        i_req = 1'b0; d_req = 1'b0; reset_n = 1'b0;
        cur_v = 1'b0; last_d = 1'b0; exp_irdata = '0; exp_drdata = '0;
        repeat (2) tick();
        chk("rst_i_rdata", i_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        reset_n   = 1'b1;
        next_free = cyc;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, lat1, lat7;
        logic [63:0] dat1, dat7;
        reset_n = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        s_ireq = 1'b0; s_iaddr = '0;
        hold_reqs = 1'b0; rand_mode = 1'b0; next_free = 0;
        do_reset();

        // Reset in the middle of a D write drops it.
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0155; d_wdata = {$urandom, $urandom};
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        chk("t1_writeM", m_writeM, 0);
        chk("t1_busy",   busy, 0);
        chk("t1_bus",    m_data, w_mem_drive);
        do_reset();
        repeat (L + 3) tick();

        // I read at an unaligned address.
        rd_cycles = 0; done_log.delete(); done_cyc.delete();
        t0 = cyc; i_req = 1'b1; i_addr = 16'h0027;
        repeat (L + 3) tick();
        chk("t2_readM_cycles", rd_cycles, L);
        chk("t2_i_rdata", obs_i_rdata, 64'h0123_4567_89AB_CDEF);
        chk("t2_ndone", done_log.size(), 1);
        if (done_cyc.size() > 0) chk("t2_latency", done_cyc[0] - t0, L + 1);

        // D write; d_rdata must be left alone.
        wr_cycles = 0; done_log.delete(); done_cyc.delete();
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h00C1; d_wdata = 64'hDEAD_BEEF_0000_FFFF;
        repeat (L + 3) tick();
        chk("t3_writeM_cycles", wr_cycles, L);
        chk("t3_addr", obs_wr_addr, 16'h00C0);
        chk("t3_d_rdata", d_rdata, 0);
        if (done_log.size() > 0) chk("t3_owner", done_log[0], 1);

        // Contention from reset with both requests held.
        do_reset();
        done_log.delete(); done_cyc.delete();
        hold_reqs = 1'b1;
        i_req = 1'b1; i_addr = 16'h0042;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0089;
        repeat (4 * (L + 2)) tick();
        hold_reqs = 1'b0; i_req = 1'b0; d_req = 1'b0;
        repeat (2) tick();
        chk("t4_count", done_log.size(), 4);
        if (done_log.size() >= 4) begin
            for (int k = 0; k < 4; k++) chk("t4_order", done_log[k], (k % 2 == 0));
            for (int k = 0; k < 3; k++) chk("t4_spacing", done_cyc[k + 1] - done_cyc[k], L + 2);
        end

        // D request arrives in the second access cycle of an I read.
        done_log.delete(); done_cyc.delete();
        i_req = 1'b1; i_addr = 16'h0033;
        tick();
        tick();
        d_req = 1'b1; d_we = 1'($urandom_range(0, 1)); d_addr = 16'h0071; d_wdata = {$urandom, $urandom};
        repeat (2 * (L + 2) + 2) tick();
        chk("t5_count", done_log.size(), 2);
        if (done_log.size() >= 2) begin
            chk("t5_first",  done_log[0], 0);
            chk("t5_second", done_log[1], 1);
            chk("t5_gap", done_cyc[1] - done_cyc[0], L + 2);
        end

        // Randomized traffic.
        do_reset();
        rand_mode = 1'b1;
        repeat (1500) tick();
        rand_mode = 1'b0;
        repeat (3 * (L + 2)) tick();
        chk("drain_i", i_req, 0);
        chk("drain_d", d_req, 0);

        // Latency sweep: LATENCY=1 and LATENCY=7.
        lat1 = -1; lat7 = -1; dat1 = '0; dat7 = '0;
        s_iaddr = 16'h0016; s_ireq = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (s1_idone && lat1 < 0) begin lat1 = k; dat1 = s1_irdata; end
            if (s7_idone && lat7 < 0) begin lat7 = k; dat7 = s7_irdata; end
        end
        s_ireq = 1'b0;
        repeat (12) tick();
        chk("sweep1_latency", lat1, 2);
        chk("sweep7_latency", lat7, 8);
        chk("sweep1_data", dat1, init_line(8'h05) ^ 64'h1111);
        chk("sweep7_data", dat7, init_line(8'h05) ^ 64'h7777);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
